uart_rx_if: RTL

UART_RX_IF -- requirements
Module: uart_rx_if

---
 rtl/uart_rx_if.sv | 97 +++++++++
 1 files changed

// File: rtl/uart_rx_if.sv
// uart_rx_if: 8N1 UART receiver with a one-entry valid/ready holding register.
// The frame FSM never stalls; when the holding register is full, a new byte is dropped and overrun pulses.
module uart_rx_if #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] uart_rx,
    output logic       uart_valid,
    input  logic       uart_ready,
    output logic       frame_err,
    output logic       overrun
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t        r_state, w_state_n;
    logic          r_sync1, r_sync2;
    logic [CW-1:0] r_cnt, w_cnt_n;
    logic [2:0]    r_idx, w_idx_n;
    logic [7:0]    r_shift, w_shift_n;
    logic          w_deliver, w_ferr, w_load, w_drop;

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt + 1'b1;
        w_idx_n   = r_idx;
        w_shift_n = r_shift;
        w_deliver = 1'b0;
        w_ferr    = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_n = '0;
                if (!r_sync2) w_state_n = START;
            end
            START: if (r_cnt == HALF) begin
                w_cnt_n   = '0;
                w_idx_n   = '0;
                w_state_n = r_sync2 ? IDLE : DATA;
            end
            DATA: if (r_cnt == FULL) begin
                w_cnt_n   = '0;
                w_shift_n = {r_sync2, r_shift[7:1]};
                w_idx_n   = r_idx + 1'b1;
                if (r_idx == 3'd7) w_state_n = STOP;
            end
            STOP: if (r_cnt == FULL) begin
                w_cnt_n   = '0;
                w_deliver = r_sync2;
                w_ferr    = ~r_sync2;
                w_state_n = r_sync2 ? IDLE : BREAK;
            end
            BREAK: begin
                w_cnt_n = '0;
                if (r_sync2) w_state_n = IDLE;
            end
            default: w_state_n = IDLE;
        endcase
        // The slot is free if it is empty now or is being handed over on this same edge.
        w_load = w_deliver & (~uart_valid | uart_ready);
        w_drop = w_deliver & ~w_load;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_shift    <= '0;
            uart_rx    <= 8'h00;
            uart_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            r_sync1   <= rxd;
            r_sync2   <= r_sync1;
            r_state   <= w_state_n;
            r_cnt     <= w_cnt_n;
            r_idx     <= w_idx_n;
            r_shift   <= w_shift_n;
            frame_err <= w_ferr;
            overrun   <= w_drop;
            if (w_load) begin
                uart_rx    <= r_shift;
                uart_valid <= 1'b1;
            end else if (uart_ready) begin
                uart_valid <= 1'b0;
            end
        end
    end
endmodule
